// File: rtl/clock_pkg.sv
// Shared types and constants for the time-set controller and its BCD field adjuster.
package clock_pkg;

    // Controller modes: free-running, or editing one of the three fields.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Wrap points of the two kinds of field.
    localparam int HR_MAX = 23;
    localparam int MS_MAX = 59;

    // Per-digit limits derived from the wrap points.
    localparam logic [BCD_W-1:0] HR_MAX_TENS = BCD_W'(HR_MAX / 10);
    localparam logic [BCD_W-1:0] HR_MAX_ONES = BCD_W'(HR_MAX % 10);
    localparam logic [BCD_W-1:0] MS_MAX_TENS = BCD_W'(MS_MAX / 10);
    localparam logic [BCD_W-1:0] MS_MAX_ONES = BCD_W'(MS_MAX % 10);

    // True when a two-digit BCD value is legal and no greater than max_tens:max_ones.
    function automatic logic bcd_in_range(
        input logic [BCD_W-1:0] tens,
        input logic [BCD_W-1:0] ones,
        input logic [BCD_W-1:0] max_tens,
        input logic [BCD_W-1:0] max_ones
    );
        logic ok;
        ok = (ones <= 4'd9) && (tens <= max_tens);
        if (tens == max_tens) begin
            ok = ok && (ones <= max_ones);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_field_adj.sv
// Combinational +1 / -1 of a two-digit BCD field with wrap at 00 and at max.
// An out-of-range input is forced to 00 by the first adjustment.
module bcd_field_adj
    import clock_pkg::*;
(
    input  logic [BCD_W-1:0] tens,
    input  logic [BCD_W-1:0] ones,
    input  logic             inc,
    input  logic             dec,
    input  logic [BCD_W-1:0] max_tens,
    input  logic [BCD_W-1:0] max_ones,
    output logic [BCD_W-1:0] tens_adj,
    output logic [BCD_W-1:0] ones_adj
);

    // Compute the adjusted field; pass through unchanged unless exactly one of inc/dec is set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        tens_adj = tens;
        ones_adj = ones;
        if (inc ^ dec) begin
            if (!bcd_in_range(tens, ones, max_tens, max_ones)) begin
                tens_adj = '0;
                ones_adj = '0;
            end else if (inc) begin
                if (tens == max_tens && ones == max_ones) begin
                    tens_adj = '0;
                    ones_adj = '0;
                end else if (ones == 4'd9) begin
                    tens_adj = tens + 4'd1;
                    ones_adj = '0;
                end else begin
                    ones_adj = ones + 4'd1;
                end
            end else begin
                if (tens == 4'd0 && ones == 4'd0) begin
                    tens_adj = max_tens;
                    ones_adj = max_ones;
                end else if (ones == 4'd0) begin
                    tens_adj = tens - 4'd1;
                    ones_adj = 4'd9;
                end else begin
                    ones_adj = ones - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: sequences the hh:mm:ss counter between free-running and a
// three-field edit mode, and issues a one-cycle parallel load when editing ends.
module clock_set_ctrl
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1s,
    input  logic             mode_btn,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic [BCD_W-1:0] cur_sec_ones,
    input  logic [BCD_W-1:0] cur_sec_tens,
    input  logic [BCD_W-1:0] cur_min_ones,
    input  logic [BCD_W-1:0] cur_min_tens,
    input  logic [BCD_W-1:0] cur_hr_ones,
    input  logic [BCD_W-1:0] cur_hr_tens,
    output logic             run_en,
    output logic             load,
    output logic [BCD_W-1:0] load_sec_ones,
    output logic [BCD_W-1:0] load_sec_tens,
    output logic [BCD_W-1:0] load_min_ones,
    output logic [BCD_W-1:0] load_min_tens,
    output logic [BCD_W-1:0] load_hr_ones,
    output logic [BCD_W-1:0] load_hr_tens,
    output logic [2:0]       edit_sel,
    output logic             blink
);

    state_t state;
    state_t next_state;

    logic mode_q;
    logic inc_q;
    logic dec_q;
    logic btn_armed;

    logic mode_edge;
    logic inc_edge;
    logic dec_edge;
    logic adj_en;
    logic adj_inc;
    logic adj_dec;
    logic capture;
    logic load_next;

    logic [BCD_W-1:0] hr_tens_adj;
    logic [BCD_W-1:0] hr_ones_adj;
    logic [BCD_W-1:0] min_tens_adj;
    logic [BCD_W-1:0] min_ones_adj;
    logic [BCD_W-1:0] sec_tens_adj;
    logic [BCD_W-1:0] sec_ones_adj;

    // Previous button levels. The arm flag stays low for the first clock after reset so
    // that a button already held through reset release is sampled without producing an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            btn_armed <= 1'b0;
        end else begin
            mode_q    <= mode_btn;
            inc_q     <= inc_btn;
            dec_q     <= dec_btn;
            btn_armed <= 1'b1;
        end
    end

    assign mode_edge = btn_armed & mode_btn & ~mode_q;
    assign inc_edge  = btn_armed & inc_btn  & ~inc_q;
    assign dec_edge  = btn_armed & dec_btn  & ~dec_q;

    // A field adjusts only in edit mode, with no mode edge, and with exactly one of inc/dec.
    assign adj_en  = (state != RUN) & ~mode_edge & (inc_edge ^ dec_edge);
    assign adj_inc = adj_en & inc_edge;
    assign adj_dec = adj_en & dec_edge;
    assign capture = (state == RUN) & mode_edge;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and load-request decode; mode edges step RUN->HR->MIN->SEC->RUN.
    always_comb begin
        next_state = state;
        load_next  = 1'b0;
        if (mode_edge) begin
            case (state)
                RUN:     next_state = SET_HR;
                SET_HR:  next_state = SET_MIN;
                SET_MIN: next_state = SET_SEC;
                SET_SEC: begin
                    next_state = RUN;
                    load_next  = 1'b1;
                end
                default: next_state = RUN;
            endcase
        end
    end

    // Field-select decode and counter enable, both straight from registered state.
    always_comb begin
        edit_sel = 3'b000;
        case (state)
            SET_HR:  edit_sel = 3'b100;
            SET_MIN: edit_sel = 3'b010;
            SET_SEC: edit_sel = 3'b001;
            default: edit_sel = 3'b000;
        endcase
        run_en = tick_1s & (state == RUN) & ~load;
    end

    bcd_field_adj u_hr_adj (
        .tens     (load_hr_tens),
        .ones     (load_hr_ones),
        .inc      (adj_inc & (state == SET_HR)),
        .dec      (adj_dec & (state == SET_HR)),
        .max_tens (HR_MAX_TENS),
        .max_ones (HR_MAX_ONES),
        .tens_adj (hr_tens_adj),
        .ones_adj (hr_ones_adj)
    );

    bcd_field_adj u_min_adj (
        .tens     (load_min_tens),
        .ones     (load_min_ones),
        .inc      (adj_inc & (state == SET_MIN)),
        .dec      (adj_dec & (state == SET_MIN)),
        .max_tens (MS_MAX_TENS),
        .max_ones (MS_MAX_ONES),
        .tens_adj (min_tens_adj),
        .ones_adj (min_ones_adj)
    );

    bcd_field_adj u_sec_adj (
        .tens     (load_sec_tens),
        .ones     (load_sec_ones),
        .inc      (adj_inc & (state == SET_SEC)),
        .dec      (adj_dec & (state == SET_SEC)),
        .max_tens (MS_MAX_TENS),
        .max_ones (MS_MAX_ONES),
        .tens_adj (sec_tens_adj),
        .ones_adj (sec_ones_adj)
    );

    // Edit registers: capture the live time on entry to edit mode, then follow the adjusters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_hr_tens  <= '0;
            load_hr_ones  <= '0;
            load_min_tens <= '0;
            load_min_ones <= '0;
            load_sec_tens <= '0;
            load_sec_ones <= '0;
        end else if (capture) begin
            load_hr_tens  <= cur_hr_tens;
            load_hr_ones  <= cur_hr_ones;
            load_min_tens <= cur_min_tens;
            load_min_ones <= cur_min_ones;
            load_sec_tens <= cur_sec_tens;
            load_sec_ones <= cur_sec_ones;
        end else if (state != RUN) begin
            load_hr_tens  <= hr_tens_adj;
            load_hr_ones  <= hr_ones_adj;
            load_min_tens <= min_tens_adj;
            load_min_ones <= min_ones_adj;
            load_sec_tens <= sec_tens_adj;
            load_sec_ones <= sec_ones_adj;
        end
    end

    // One-cycle load strobe, raised by the mode edge that leaves SET_SEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load <= 1'b0;
        end else begin
            load <= load_next;
        end
    end

    // Blink phase: toggles per tick while editing, cleared in RUN and on any adjustment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink <= 1'b0;
        end else if (state == RUN || next_state == RUN || adj_en) begin
            blink <= 1'b0;
        end else if (tick_1s) begin
            blink <= ~blink;
        end
    end

endmodule
